// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage that sits directly after the next-PC select mux.
// It owns the architectural PC, hands pc_plus4 back to the mux and takes the
// mux result back as pc_next. It keeps at most one instruction-memory request
// in flight. Returned words go into a one-entry IF/ID buffer, or into a
// one-entry skid register when decode is stalled. A redirect (taken branch or
// jump) flushes everything the stage holds and restarts fetch at the target.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   pc_next         next PC from the select mux (pc_plus4 or redirect target)
//   redirect        taken branch/jump, same signal as the mux select
//   pc_plus4        pc_q + 4, feeds the mux
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_addr       fetch address (always pc_q)
//   imem_rsp_valid  one-cycle response pulse from memory
//   imem_rsp_data   returned instruction word
//   id_ready        decode consumes the buffered instruction this cycle
//   if_valid        output buffer holds a valid instruction
//   if_pc           PC of the buffered instruction
//   if_instr        buffered instruction word
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  redirect,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  id_ready,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0] skid_instr;
    logic                  kill;

    logic in_fetch;
    logic in_wait;
    logic in_hold;
    logic req_fire;
    logic slot_free;
    logic rsp_live;
    logic load_rsp;
    logic park_rsp;
    logic load_skid;

    // State decode and the handshake/qualifier terms shared by the registers
    // below. A response is only "live" when it is not being killed by an
    // earlier redirect or by a redirect in the same cycle. The output slot
    // counts as free when it is empty or is being drained this cycle.
    assign in_fetch  = (state == ST_FETCH);
    assign in_wait   = (state == ST_WAIT);
    assign in_hold   = (state == ST_HOLD);
    assign slot_free = ~if_valid | id_ready;
    assign rsp_live  = in_wait & imem_rsp_valid & ~kill & ~redirect;
    assign load_rsp  = rsp_live & slot_free;
    assign park_rsp  = rsp_live & ~slot_free;
    assign load_skid = in_hold & ~redirect & id_ready;

    // Request side. The request is suppressed in a redirect cycle because
    // pc_q is about to be replaced by the target, and it is forced low
    // while reset is held.
    assign imem_req_valid = in_fetch & ~redirect & ~rst;
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_plus4       = pc_q + ADDR_WIDTH'(4);

    // Architectural PC. It advances to pc_next when a request is accepted.
    // It also follows a redirect in any state, so the next fetch goes to the
    // branch target no matter what is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect || req_fire) begin
            pc_q <= pc_next;
        end
    end

    // Remember the address of the outstanding request. The response is then
    // tagged with the PC that produced it, even though pc_q has moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc <= '0;
        end else if (req_fire) begin
            req_pc <= pc_q;
        end
    end

    // Fetch sequencer. WAIT covers the one outstanding request. kill records
    // a redirect that arrived while the response was still owed, so that the
    // stale word is thrown away when it shows up. HOLD parks a response that
    // found the output buffer full. It waits there until decode drains the
    // buffer or a redirect discards the parked word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
            kill  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (req_fire) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        if (imem_rsp_valid) begin
                            state <= ST_FETCH;
                            kill  <= 1'b0;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        kill <= 1'b0;
                        if (kill || slot_free) begin
                            state <= ST_FETCH;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect || id_ready) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

    // Skid register. It catches a live response when the output buffer is
    // occupied and decode is not draining it. A redirect out of HOLD simply
    // leaves the stale contents behind, and they are never read again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (park_rsp) begin
            skid_pc    <= req_pc;
            skid_instr <= imem_rsp_data;
        end
    end

    // IF/ID output buffer. Redirect wins over every load so that no
    // wrong-path instruction reaches decode. A load in the same cycle as a
    // drain keeps if_valid high for back-to-back delivery. A drain with no
    // load empties the slot. With no drain and no load, the contents stay
    // untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (load_rsp) begin
            if_valid <= 1'b1;
            if_pc    <= req_pc;
            if_instr <= imem_rsp_data;
        end else if (load_skid) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
        end else if (id_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Bench for if_fetch_stage. The bench plays three roles around the DUT:
//   - the next-PC mux, feeding pc_next back from pc_plus4 or a branch target
//   - the instruction memory, which has random request-ready and 1..3 cycle
//     response latency
//   - the decode stage, which has random id_ready
// The reference is the program-order view. Each accepted fetch should be the
// model PC, which steps by 4 unless a redirect replaces it. Every response
// that no redirect has cancelled is queued as an expected {pc, instr}. Decode
// must see those entries in order. A redirect cancels everything not yet
// consumed.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] target;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    bit          pend;
    bit          pend_kill;
    logic [31:0] pend_addr;
    int          pend_due;
    int          cyc;
    bit          prev_redir;
    bit          mon_en;
    int          delivered;

    int          p_redir;
    int          p_ready;
    int          p_idrdy;
    int          lat_lo;
    int          lat_hi;
    bit          force_redir;
    logic [31:0] force_target;

    int          tests;
    int          fails;

    always #5 clk = ~clk;

    // The bench is the select mux in front of the stage.
    assign pc_next = redirect ? target : pc_plus4;

    if_fetch_stage #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_next        (pc_next),
        .redirect       (redirect),
        .pc_plus4       (pc_plus4),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    // Memory image: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(3))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFF8;
            2:       return 32'hFFFF_FFFC;
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus. It first drives the mux, memory and decode inputs
    // for this cycle, and issues any response that is due. Once the
    // combinational outputs settle, it checks the request side against the
    // model PC.
    task automatic applyStimulus();
        bit          busy;
        bit          exp_req;
        logic [31:0] next_pc;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_redir) exp_q.delete();
        redirect       = force_redir || ($urandom_range(99) < p_redir);
        target         = force_redir ? force_target : pick_target();
        force_redir    = 1'b0;
        id_ready       = ($urandom_range(99) < p_idrdy);
        imem_req_ready = ($urandom_range(99) < p_ready);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
        busy           = pend;
        if (pend && cyc >= pend_due) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            if (!pend_kill && !redirect)
                exp_q.push_back('{pc: pend_addr, instr: mem_word(pend_addr), cyc: cyc});
            pend = 1'b0;
        end else if (pend && redirect) begin
            pend_kill = 1'b1;
        end
        prev_redir = redirect;
        #1;
        checkOutput("pc_plus4", pc_plus4, model_pc + 32'd4);
        exp_req = !redirect && !busy && (exp_q.size() < 2);
        checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));
        next_pc = model_pc;
        if (imem_req_valid && imem_req_ready) begin
            checkOutput("req_addr", imem_addr, model_pc);
            pend      = 1'b1;
            pend_kill = 1'b0;
            pend_addr = model_pc;
            pend_due  = cyc + $urandom_range(lat_hi, lat_lo);
            next_pc   = model_pc + 32'd4;
        end
        if (redirect) next_pc = target;
        model_pc = next_pc;
    endtask

    task automatic idleInputs();
        redirect       = 1'b0;
        target         = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b0;
    endtask

    task automatic clearModel();
        exp_q.delete();
        pend       = 1'b0;
        pend_kill  = 1'b0;
        prev_redir = 1'b0;
        model_pc   = RESET_PC;
    endtask

    // Monitor. At the falling edge, any valid output must be the oldest
    // expected entry, which is popped if decode takes it. An entry that was
    // queued in an earlier cycle must already be showing as valid.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (exp_q.size() == 0) begin
                    checkOutput("if_valid_spurious", 32'(if_valid), 32'd0);
                end else if (if_valid) begin
                    checkOutput("if_pc", if_pc, exp_q[0].pc);
                    checkOutput("if_instr", if_instr, exp_q[0].instr);
                    if (id_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end else if (exp_q[0].cyc < cyc) begin
                    checkOutput("if_valid_late", 32'(if_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        int d0;
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        delivered   = 0;
        mon_en      = 1'b0;
        force_redir = 1'b0;
        force_target = 32'h0;
        p_redir = 0; p_ready = 100; p_idrdy = 100; lat_lo = 1; lat_hi = 1;
        rst = 1'b1;
        idleInputs();
        clearModel();

        #2;
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_instr", if_instr, 32'h0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC);
        checkOutput("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Zero-wait memory with decode always ready: the stream 0x0, 0x4, 0x8...
        repeat (12) applyStimulus();

        // Request-ready stall, then acceptance.
        p_ready = 0;
        repeat (3) applyStimulus();
        p_ready = 100;
        repeat (4) applyStimulus();

        // Fetch across the top of the address space.
        force_redir  = 1'b1;
        force_target = 32'hFFFF_FFF8;
        repeat (10) applyStimulus();

        // Randomized traffic with knobs reshuffled every 200 cycles.
        for (int blk = 0; blk < 15; blk++) begin
            p_redir = $urandom_range(15);
            p_ready = $urandom_range(100, 30);
            p_idrdy = $urandom_range(100, 20);
            lat_lo  = 1;
            lat_hi  = $urandom_range(3, 1);
            repeat (200) applyStimulus();
        end

        // Clean drain: the stream must keep moving.
        p_redir = 0; p_ready = 100; p_idrdy = 100; lat_lo = 1; lat_hi = 2;
        d0 = delivered;
        repeat (30) applyStimulus();
        checkOutput("progress", 32'(delivered > d0), 32'd1);

        // Stall decode so that two fetches fill the buffer and the skid, then
        // reset in the middle of a cycle.
        p_idrdy = 0; lat_hi = 1;
        repeat (10) applyStimulus();
        @(posedge clk);
        #3;
        rst = 1'b1;
        idleInputs();
        #1;
        checkOutput("midrst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("midrst_imem_addr", imem_addr, RESET_PC);
        clearModel();
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        p_idrdy = 100;
        repeat (10) applyStimulus();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
